// File: rtl/mux21_arbiter_pkg.sv
// Shared types and helpers for the mux21 round-robin arbiter.
package mux21_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT0   = 2'd1,
    ST_GNT1   = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;

  // One-hot grant vector for requester o.
  function automatic logic [1:0] gnt_vec(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  // Grant state belonging to requester o.
  function automatic state_t gnt_state(input logic o);
    return o ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/mux21_arbiter_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module mux21_arb_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Clear has priority over enable; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1 mux, with bounded
// hold time and a dead gap on every ownership change.
module mux21_arbiter
  import mux21_arbiter_pkg::*;
#(
  parameter int MAX_HOLD   = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy
);

  state_t           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic             last_q, last_d;
  logic             sel_d, busy_d;
  logic [1:0]       gnt_d;
  logic [CNT_W-1:0] hold_cnt, gap_cnt;
  logic             hold_clr, gap_clr;

  // Counters run on the upcoming state: entering a grant or the gap loads 1,
  // so the value seen in a state is the 1-based cycle count within it.
  assign hold_clr = !((state_d == ST_GNT0) || (state_d == ST_GNT1));
  assign gap_clr  = (state_d != ST_SWITCH);

  mux21_arb_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr),
    .en  (!hold_clr),
    .cnt (hold_cnt)
  );

  mux21_arb_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (gap_clr),
    .en  (!gap_clr),
    .cnt (gap_cnt)
  );

  // Next-state and next-output selection.
  always_comb begin
    logic k, o, own, other, hold_hit, gap_done;
    state_d  = state_q;
    tgt_d    = tgt_q;
    last_d   = last_q;
    sel_d    = sel;
    gnt_d    = GNT_NONE;
    o        = 1'b0;
    k        = (state_q == ST_GNT1);
    own      = req[k];
    other    = req[~k];
    hold_hit = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    gap_done = (gap_cnt == CNT_W'(GAP_CYCLES));
    unique case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          o       = (req == 2'b11) ? ~last_q : req[1];
          state_d = gnt_state(o);
          gnt_d   = gnt_vec(o);
          sel_d   = o;
          last_d  = o;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if ((!own && other) || (own && other && hold_hit)) begin
          state_d = ST_SWITCH;
          tgt_d   = ~k;
          sel_d   = ~k;
        end else if (!own) begin
          state_d = ST_IDLE;
        end else begin
          gnt_d = gnt_vec(k);
        end
      end
      ST_SWITCH: begin
        if (gap_done) begin
          if (req[tgt_q] || req[~tgt_q]) begin
            o       = req[tgt_q] ? tgt_q : ~tgt_q;
            state_d = gnt_state(o);
            gnt_d   = gnt_vec(o);
            sel_d   = o;
            last_d  = o;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      last_q  <= 1'b1;
      sel     <= 1'b0;
      gnt     <= GNT_NONE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      last_q  <= last_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed and random checks of mux21_arbiter (MAX_HOLD=4 and MAX_HOLD=0 builds).
module tb_mux21_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt, gnt0;
  logic       sel, sel0, busy, busy0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux21_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1), .CNT_W(4)) dut (
    .clk (clk), .rst (rst), .req (req), .gnt (gnt), .sel (sel), .busy (busy)
  );

  mux21_arbiter #(.MAX_HOLD(0), .GAP_CYCLES(1), .CNT_W(4)) dut0 (
    .clk (clk), .rst (rst), .req (req), .gnt (gnt0), .sel (sel0), .busy (busy0)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what the main DUT must show after the
  // edge, then pop and compare once the edge has passed.
  task automatic step(input string tag, input logic r, input logic [1:0] rq,
                      input logic [1:0] eg, input logic es, input logic eb);
    exp_t e;
    rst = r;
    req = rq;
    sb.push_back('{tag, eg, es, eb});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_gnt"},  {2'b00, gnt},  {2'b00, e.gnt});
    check({e.tag, "_sel"},  {3'b000, sel},  {3'b000, e.sel});
    check({e.tag, "_busy"}, {3'b000, busy}, {3'b000, e.busy});
  endtask

  initial begin
    logic [1:0] i_vec;
    logic [1:0] pg, pg0;
    logic       ps, ps0;
    i_vec = 2'b10;

    // reset
    step("rst_a", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    step("rst_b", 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);

    // 1: single requester, then release
    step("t1_g0", 1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) step("t1_hold", 1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
    step("t1_rel", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step("t1_idle", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // 2: both requesting after reset, strict alternation with preemption
    step("t2_rst", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int n = 0; n < 4; n++) step("t2_g0", 1'b0, 2'b11, 2'b01, 1'b0, 1'b1);
      step("t2_gap1", 1'b0, 2'b11, 2'b00, 1'b1, 1'b1);
      check("t2_z1", {3'b000, i_vec[sel]}, 4'h1);
      for (int n = 0; n < 4; n++) step("t2_g1", 1'b0, 2'b11, 2'b10, 1'b1, 1'b1);
      step("t2_gap0", 1'b0, 2'b11, 2'b00, 1'b0, 1'b1);
      check("t2_z0", {3'b000, i_vec[sel]}, 4'h0);
    end
    step("t2_rel", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // 3: owner drops while other raises on the same edge
    step("t3_g0", 1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
    step("t3_sw", 1'b0, 2'b10, 2'b00, 1'b1, 1'b1);
    step("t3_g1", 1'b0, 2'b10, 2'b10, 1'b1, 1'b1);
    step("t3_rel", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);

    // 4: target withdraws during the gap, original side takes it back
    step("t4_g0", 1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
    step("t4_sw", 1'b0, 2'b10, 2'b00, 1'b1, 1'b1);
    step("t4_back", 1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
    step("t4_rel", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // 5: reset mid-grant and mid-gap
    step("t5_g1", 1'b0, 2'b10, 2'b10, 1'b1, 1'b1);
    step("t5_g1b", 1'b0, 2'b10, 2'b10, 1'b1, 1'b1);
    step("t5_rst", 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    step("t5_tie", 1'b0, 2'b11, 2'b01, 1'b0, 1'b1);
    step("t5_sw", 1'b0, 2'b10, 2'b00, 1'b1, 1'b1);
    step("t5_rstgap", 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    step("t5_after", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step("t5_after2", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // 6: no-preemption build keeps the owner while both request
    rst = 1'b1;
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 2'b11;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      check("t6_hold", {gnt0, sel0, busy0}, {2'b01, 1'b0, 1'b1});
    end

    // 6: invariants on both builds under random requests
    pg = gnt; ps = sel; pg0 = gnt0; ps0 = sel0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(3) == 0) req = 2'($urandom_range(3));
      @(posedge clk);
      #1;
      check("inv_onehot", {3'b000, gnt == 2'b11}, 4'h0);
      check("inv_onehot0", {3'b000, gnt0 == 2'b11}, 4'h0);
      if (gnt != 2'b00) check("inv_sel", {3'b000, sel}, {3'b000, gnt[1]});
      if (gnt0 != 2'b00) check("inv_sel0", {3'b000, sel0}, {3'b000, gnt0[1]});
      if (gnt != 2'b00 && pg != 2'b00) check("inv_stable", {3'b000, sel}, {3'b000, ps});
      if (gnt0 != 2'b00 && pg0 != 2'b00) check("inv_stable0", {3'b000, sel0}, {3'b000, ps0});
      check("inv_busy", {3'b000, busy}, {3'b000, (gnt != 2'b00) || busy});
      pg = gnt; ps = sel; pg0 = gnt0; ps0 = sel0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
